// File: rtl/poly_unpack_decompress.sv
// Kyber decode path: unpacks LSB-first d-bit fields from 32-bit words and
// decompresses each to round(Q*y / 2^d), one coefficient per cycle.
module poly_unpack_decompress #(
    parameter int unsigned Q      = 3329,
    parameter int unsigned N_COEF = 256,
    parameter int unsigned W      = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   d_sel,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [11:0]  out_coef,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      r_state;
    logic [63:0] r_buf;
    logic [6:0]  r_cnt;
    logic [3:0]  r_d;
    logic [6:0]  r_words;
    logic [8:0]  r_coefs;

    logic [3:0]  w_dsel_d;
    logic        w_dsel_ok;
    logic [6:0]  w_dcnt;
    logic [6:0]  w_nwords;
    logic        w_acc;
    logic        w_ext;
    logic [10:0] w_y;
    logic [22:0] w_round;
    logic [11:0] w_coef;
    logic [63:0] w_shift;
    logic [6:0]  w_pos;
    logic [63:0] w_ins;
    logic [63:0] w_buf_nxt;
    logic [6:0]  w_cnt_nxt;

    always_comb begin
        w_dsel_d  = 4'd0;
        w_dsel_ok = 1'b1;
        case (d_sel)
            3'd0:    w_dsel_d = 4'd1;
            3'd1:    w_dsel_d = 4'd4;
            3'd2:    w_dsel_d = 4'd5;
            3'd3:    w_dsel_d = 4'd10;
            3'd4:    w_dsel_d = 4'd11;
            default: w_dsel_ok = 1'b0;
        endcase
    end

    assign w_dcnt   = {3'b000, r_d};
    assign w_nwords = {r_d, 3'b000};
    assign busy     = (r_state == RUN);
    assign in_ready = (r_state == RUN) && (r_cnt <= 7'(W)) && (r_words < w_nwords);
    assign w_acc    = in_ready && in_valid;
    assign w_ext    = (r_state == RUN) && (r_cnt >= w_dcnt) && (!out_valid || out_ready)
                      && (r_coefs < 9'(N_COEF));

    // Rounded decompression; Q*2047 + 1024 still fits in 23 bits.
    assign w_y     = r_buf[10:0] & ~(11'h7FF << r_d);
    assign w_round = 23'(Q) * {12'b0, w_y} + (23'd1 << (r_d - 4'd1));
    assign w_coef  = 12'(w_round >> r_d);

    // Bits above r_cnt are always zero, so a new word can simply be OR-ed in
    // at the post-extraction fill level.
    assign w_shift   = w_ext ? (r_buf >> r_d) : r_buf;
    assign w_pos     = w_ext ? (r_cnt - w_dcnt) : r_cnt;
    assign w_ins     = {{(64-W){1'b0}}, in_data} << w_pos;
    assign w_buf_nxt = w_acc ? (w_shift | w_ins) : w_shift;
    assign w_cnt_nxt = w_pos + (w_acc ? 7'(W) : 7'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_buf     <= '0;
            r_cnt     <= '0;
            r_d       <= 4'd1;
            r_words   <= '0;
            r_coefs   <= '0;
            out_coef  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && w_dsel_ok) begin
                        r_d     <= w_dsel_d;
                        r_buf   <= '0;
                        r_cnt   <= '0;
                        r_words <= '0;
                        r_coefs <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_buf <= w_buf_nxt;
                    r_cnt <= w_cnt_nxt;
                    if (w_acc) r_words <= r_words + 7'd1;
                    if (w_ext) begin
                        out_coef  <= w_coef;
                        out_valid <= 1'b1;
                        out_last  <= (r_coefs == 9'(N_COEF - 1));
                        r_coefs   <= r_coefs + 9'd1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                    if (out_valid && out_ready && out_last) begin
                        r_state <= IDLE;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
